encoded_memory_decoder: RTL and testbench

Read-side companion to the encoded memory, which stores each written byte as the absolute difference |number − mask[index]| against a fixed 8-entry mask table. This block issues reads to that memory's read port, one index or a full 0–7 sweep. It reconstructs both candidate original values per entry (mask + diff, mask − diff) and flags which candidates are arithmetically possible in 8 bits. It sits between the encoded memory and any consumer that needs plaintext back.

---
 rtl/encoded_memory_decoder.sv | 153 +++++++++++++++
 tb/tb_encoded_memory_decoder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/encoded_memory_decoder.sv
// encoded_memory_decoder: reads |number - mask| entries back from the encoded
// memory and rebuilds both candidate plaintexts with their 8-bit feasibility.
module encoded_memory_decoder (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       start,
  input  logic       sweep,
  input  logic [2:0] index,
  output logic       mem_rd,
  output logic [2:0] mem_index,
  input  logic [7:0] mem_data,
  output logic       busy,
  output logic       valid,
  output logic [2:0] out_index,
  output logic [7:0] value_hi,
  output logic [7:0] value_lo,
  output logic       hi_ok,
  output logic       lo_ok,
  output logic       unique_o,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e     state_q;
  logic       sweep_q;
  logic [2:0] cur_q;
  logic       rd_q;
  logic [2:0] mem_idx_q;
  logic       busy_q;
  logic       valid_q;
  logic       done_q;
  logic [2:0] out_idx_q;
  logic [7:0] hi_q;
  logic [7:0] lo_q;
  logic       hi_ok_q;
  logic       lo_ok_q;
  logic       uniq_q;

  logic [7:0] mask;
  logic [8:0] sum_d;
  logic [7:0] lo_d;
  logic       hi_ok_d;
  logic       lo_ok_d;
  logic       uniq_d;
  logic       last_d;
  logic [2:0] first_idx;

  // Fixed mask table shared with the encoding side
  always_comb begin
    mask = 8'h00;
    unique case (cur_q)
      3'd0: mask = 8'h00;
      3'd1: mask = 8'h55;
      3'd2: mask = 8'hAA;
      3'd3: mask = 8'h33;
      3'd4: mask = 8'hCC;
      3'd5: mask = 8'h0F;
      3'd6: mask = 8'hF0;
      3'd7: mask = 8'hFF;
      default: mask = 8'h00;
    endcase
  end

  always_comb begin
    sum_d     = {1'b0, mask} + {1'b0, mem_data};
    lo_d      = mask - mem_data;
    hi_ok_d   = ~sum_d[8];
    lo_ok_d   = (mem_data <= mask);
    uniq_d    = (hi_ok_d ^ lo_ok_d) | (mem_data == 8'h00);
    last_d    = ~sweep_q | (cur_q == 3'd7);
    first_idx = sweep ? 3'd0 : index;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      sweep_q   <= 1'b0;
      cur_q     <= 3'd0;
      rd_q      <= 1'b0;
      mem_idx_q <= 3'd0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      out_idx_q <= 3'd0;
      hi_q      <= 8'h00;
      lo_q      <= 8'h00;
      hi_ok_q   <= 1'b0;
      lo_ok_q   <= 1'b0;
      uniq_q    <= 1'b0;
    end else begin
      rd_q    <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            sweep_q   <= sweep;
            cur_q     <= first_idx;
            mem_idx_q <= first_idx;
            rd_q      <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= REQ;
          end
        end
        REQ: begin
          state_q <= WAIT;
        end
        WAIT: begin
          valid_q   <= 1'b1;
          done_q    <= last_d;
          out_idx_q <= cur_q;
          hi_q      <= sum_d[7:0];
          lo_q      <= lo_d;
          hi_ok_q   <= hi_ok_d;
          lo_ok_q   <= lo_ok_d;
          uniq_q    <= uniq_d;
          if (last_d) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            // Overlap the next read with this result
            cur_q     <= cur_q + 3'd1;
            mem_idx_q <= cur_q + 3'd1;
            rd_q      <= 1'b1;
            state_q   <= REQ;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_rd    = rd_q;
  assign mem_index = mem_idx_q;
  assign busy      = busy_q;
  assign valid     = valid_q;
  assign done      = done_q;
  assign out_index = out_idx_q;
  assign value_hi  = hi_q;
  assign value_lo  = lo_q;
  assign hi_ok     = hi_ok_q;
  assign lo_ok     = lo_ok_q;
  assign unique_o  = uniq_q;

endmodule

// File: tb/tb_encoded_memory_decoder.sv
// tb_encoded_memory_decoder: random and directed decodes against an
// arithmetic reference and a registered memory model.
module tb_encoded_memory_decoder;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       start;
  logic       sweep;
  logic [2:0] index;
  logic       mem_rd;
  logic [2:0] mem_index;
  logic [7:0] mem_data = 8'h00;
  logic       busy;
  logic       valid;
  logic [2:0] out_index;
  logic [7:0] value_hi;
  logic [7:0] value_lo;
  logic       hi_ok;
  logic       lo_ok;
  logic       unique_o;
  logic       done;

  int errs = 0;
  int checks = 0;
  int masks [8] = '{8'h00, 8'h55, 8'hAA, 8'h33, 8'hCC, 8'h0F, 8'hF0, 8'hFF};
  logic [7:0] mem [8];

  encoded_memory_decoder dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .sweep(sweep),
    .index(index), .mem_rd(mem_rd), .mem_index(mem_index),
    .mem_data(mem_data), .busy(busy), .valid(valid),
    .out_index(out_index), .value_hi(value_hi), .value_lo(value_lo),
    .hi_ok(hi_ok), .lo_ok(lo_ok), .unique_o(unique_o), .done(done)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (mem_rd) mem_data <= mem[mem_index];

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_result(input int k);
    int m, d, hi, lo;
    bit hok, lok;
    m   = masks[k];
    d   = int'(mem[k]);
    hi  = (m + d) % 256;
    lo  = (m - d + 256) % 256;
    hok = (m + d) <= 255;
    lok = d <= m;
    chk("valid", int'(valid), 1);
    chk("out_index", int'(out_index), k);
    chk("value_hi", int'(value_hi), hi);
    chk("value_lo", int'(value_lo), lo);
    chk("hi_ok", int'(hi_ok), int'(hok));
    chk("lo_ok", int'(lo_ok), int'(lok));
    chk("unique", int'(unique_o), int'((hok != lok) || d == 0));
  endtask

  task automatic do_single(input int k);
    @(negedge CLK);
    start = 1'b1; sweep = 1'b0; index = 3'(k);
    @(posedge CLK); #1;
    chk("s_rd", int'(mem_rd), 1);
    chk("s_idx", int'(mem_index), k);
    chk("s_busy0", int'(busy), 1);
    chk("s_val0", int'(valid), 0);
    @(negedge CLK);
    start = 1'b0; sweep = 1'($urandom); index = 3'($urandom);
    @(posedge CLK); #1;
    chk("s_rd1", int'(mem_rd), 0);
    chk("s_busy1", int'(busy), 1);
    chk("s_val1", int'(valid), 0);
    @(posedge CLK); #1;
    chk_result(k);
    chk("s_done", int'(done), 1);
    chk("s_busy2", int'(busy), 0);
    chk("s_rd2", int'(mem_rd), 0);
  endtask

  task automatic do_sweep(input bit poke, input int rst_after);
    @(negedge CLK);
    start = 1'b1; sweep = 1'b1; index = 3'($urandom);
    @(posedge CLK); #1;
    chk("w_rd0", int'(mem_rd), 1);
    chk("w_idx0", int'(mem_index), 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      start = poke && (k == 3);
      sweep = 1'b0;
      index = 3'd5;
      @(posedge CLK); #1;
      chk("w_gap", int'(valid), 0);
      chk("w_gaprd", int'(mem_rd), 0);
      @(negedge CLK);
      start = 1'b0;
      @(posedge CLK); #1;
      chk_result(k);
      chk("w_done", int'(done), int'(k == 7));
      chk("w_busy", int'(busy), int'(k != 7));
      chk("w_rd", int'(mem_rd), int'(k != 7));
      if (k != 7) chk("w_idx", int'(mem_index), k + 1);
      if (k == rst_after) begin
        #2 RST_N = 1'b0;
        #1;
        chk("r_rd", int'(mem_rd), 0);
        chk("r_val", int'(valid), 0);
        chk("r_busy", int'(busy), 0);
        chk("r_hi", int'(value_hi), 0);
        chk("r_oidx", int'(out_index), 0);
        chk("r_midx", int'(mem_index), 0);
        repeat (4) begin
          @(posedge CLK); #1;
          chk("r_noval", int'(valid), 0);
          chk("r_nord", int'(mem_rd), 0);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (3) begin
          @(posedge CLK); #1;
          chk("r_idle", int'(mem_rd | valid | busy), 0);
        end
        return;
      end
    end
    repeat (3) begin
      @(posedge CLK); #1;
      chk("w_after", int'(mem_rd | valid | busy | done), 0);
    end
  endtask

  initial begin
    RST_N = 1'b0; start = 1'b0; sweep = 1'b0; index = 3'd0;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    #3;
    chk("rst_rd", int'(mem_rd), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_val", int'(valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_flags", int'({hi_ok, lo_ok, unique_o}), 0);
    chk("rst_vals", int'({value_hi, value_lo}), 0);
    chk("rst_idx", int'({mem_index, out_index}), 0);
    @(negedge CLK);
    RST_N = 1'b1;

    mem[1] = 8'h0B; mem[7] = 8'h10; mem[0] = 8'h20; mem[3] = 8'h00;
    do_single(1);
    chk("d1_hi", int'(value_hi), 8'h60);
    chk("d1_lo", int'(value_lo), 8'h4A);
    chk("d1_u", int'(unique_o), 0);
    do_single(7);
    chk("d7_hi", int'(value_hi), 8'h0F);
    chk("d7_ok", int'({hi_ok, lo_ok, unique_o}), 3'b011);
    do_single(0);
    chk("d0_lo", int'(value_lo), 8'hE0);
    chk("d0_ok", int'({hi_ok, lo_ok, unique_o}), 3'b101);
    do_single(3);
    chk("d3_v", int'({value_hi, value_lo}), 16'h3333);
    chk("d3_ok", int'({hi_ok, lo_ok, unique_o}), 3'b111);
    @(posedge CLK); #1;
    chk("hold_val", int'(valid), 0);
    chk("hold_hi", int'(value_hi), 8'h33);
    chk("hold_idx", int'(out_index), 3);

    for (int i = 0; i < 8; i++) mem[i] = 8'(i + 1);
    do_sweep(1'b1, -1);
    chk("sw7_hi", int'(value_hi), 8'h07);
    chk("sw7_hok", int'(hi_ok), 0);

    repeat (16) begin
      for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
      if ($urandom_range(0, 3) == 0) do_sweep(1'($urandom), -1);
      else do_single(int'($urandom_range(0, 7)));
    end

    for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
    do_sweep(1'b0, 2);
    do_single(6);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
